// File: rtl/cdb_arbiter_if.sv
//----------------------------------------------------------------------------
// cdb_arbiter_if : execution-unit offers and CDB broadcast bundle
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

interface cdb_arbiter_if #(
  parameter int REQ_NUM  = 3,
  parameter int ROB_ID_W = 5,
  parameter int DATA_W   = 32
);
  logic [REQ_NUM-1:0]          req_valid;
  logic [REQ_NUM-1:0]          req_ready;
  logic [REQ_NUM*ROB_ID_W-1:0] req_rob_id;
  logic [REQ_NUM*DATA_W-1:0]   req_result;
  logic [REQ_NUM*DATA_W-1:0]   req_target_pc;
  logic [REQ_NUM-1:0]          req_jump_flag;

  logic                        cdb_valid;
  logic [ROB_ID_W-1:0]         cdb_rob_id;
  logic [DATA_W-1:0]           cdb_result;
  logic [DATA_W-1:0]           cdb_target_pc;
  logic                        cdb_jump_flag;

  // Requesters and CDB consumers
  modport master (
    output req_valid, req_rob_id, req_result, req_target_pc, req_jump_flag,
    input  req_ready,
    input  cdb_valid, cdb_rob_id, cdb_result, cdb_target_pc, cdb_jump_flag
  );

  // Arbiter
  modport slave (
    input  req_valid, req_rob_id, req_result, req_target_pc, req_jump_flag,
    output req_ready,
    output cdb_valid, cdb_rob_id, cdb_result, cdb_target_pc, cdb_jump_flag
  );
endinterface

`default_nettype wire

// File: rtl/cdb_arbiter.sv
//----------------------------------------------------------------------------
// cdb_arbiter : round-robin arbiter for the shared CDB write-back port,
//               registered broadcast, flushed on rollback
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module cdb_arbiter #(
  parameter int REQ_NUM  = 3,
  parameter int ROB_ID_W = 5,
  parameter int DATA_W   = 32
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        rdy,
  input  wire logic        rollback_flag,
  cdb_arbiter_if.slave     bus,
  output logic [31:0]      grant_cnt
);

  localparam int PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int SUM_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] C_LAST_IDX = PTR_W'(REQ_NUM - 1);

  logic [ROB_ID_W-1:0] rob_id_arr    [REQ_NUM];
  logic [DATA_W-1:0]   result_arr    [REQ_NUM];
  logic [DATA_W-1:0]   target_pc_arr [REQ_NUM];

  genvar k;
  generate
    for (k = 0; k < REQ_NUM; k++) begin : g_unpack
      assign rob_id_arr[k]    = bus.req_rob_id[k*ROB_ID_W +: ROB_ID_W];
      assign result_arr[k]    = bus.req_result[k*DATA_W +: DATA_W];
      assign target_pc_arr[k] = bus.req_target_pc[k*DATA_W +: DATA_W];
    end
  endgenerate

  logic [PTR_W-1:0]    ptr_q,           ptr_d;
  logic                cdb_valid_q,     cdb_valid_d;
  logic [ROB_ID_W-1:0] cdb_rob_id_q,    cdb_rob_id_d;
  logic [DATA_W-1:0]   cdb_result_q,    cdb_result_d;
  logic [DATA_W-1:0]   cdb_target_pc_q, cdb_target_pc_d;
  logic                cdb_jump_flag_q, cdb_jump_flag_d;
  logic [31:0]         grant_cnt_q,     grant_cnt_d;

  logic                found;
  logic [PTR_W-1:0]    win_idx;
  logic [SUM_W-1:0]    cand;
  logic                accept_en;

  // Scan starts at ptr and wraps; first valid requester wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      cand = {1'b0, ptr_q} + SUM_W'(i);
      if (cand >= SUM_W'(REQ_NUM)) begin
        cand = cand - SUM_W'(REQ_NUM);
      end
      if (!found && bus.req_valid[cand[PTR_W-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[PTR_W-1:0];
      end
    end
  end

  assign accept_en = rdy & ~rst & ~rollback_flag;

  generate
    for (k = 0; k < REQ_NUM; k++) begin : g_ready
      assign bus.req_ready[k] = accept_en & found & (win_idx == PTR_W'(k));
    end
  endgenerate

  always_comb begin
    ptr_d           = ptr_q;
    cdb_valid_d     = cdb_valid_q;
    cdb_rob_id_d    = cdb_rob_id_q;
    cdb_result_d    = cdb_result_q;
    cdb_target_pc_d = cdb_target_pc_q;
    cdb_jump_flag_d = cdb_jump_flag_q;
    grant_cnt_d     = grant_cnt_q;

    if (rollback_flag) begin
      ptr_d           = '0;
      cdb_valid_d     = 1'b0;
      cdb_rob_id_d    = '0;
      cdb_result_d    = '0;
      cdb_target_pc_d = '0;
      cdb_jump_flag_d = 1'b0;
    end else if (rdy) begin
      if (found) begin
        cdb_rob_id_d    = rob_id_arr[win_idx];
        cdb_result_d    = result_arr[win_idx];
        cdb_target_pc_d = target_pc_arr[win_idx];
        cdb_jump_flag_d = bus.req_jump_flag[win_idx];
        ptr_d           = (win_idx == C_LAST_IDX) ? '0 : win_idx + PTR_W'(1);
        // Tag 0 means "no ROB entry": consume the offer but never broadcast it.
        cdb_valid_d     = |rob_id_arr[win_idx];
        if (|rob_id_arr[win_idx]) begin
          grant_cnt_d = grant_cnt_q + 32'd1;
        end
      end else begin
        cdb_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q           <= '0;
      cdb_valid_q     <= 1'b0;
      cdb_rob_id_q    <= '0;
      cdb_result_q    <= '0;
      cdb_target_pc_q <= '0;
      cdb_jump_flag_q <= 1'b0;
      grant_cnt_q     <= '0;
    end else begin
      ptr_q           <= ptr_d;
      cdb_valid_q     <= cdb_valid_d;
      cdb_rob_id_q    <= cdb_rob_id_d;
      cdb_result_q    <= cdb_result_d;
      cdb_target_pc_q <= cdb_target_pc_d;
      cdb_jump_flag_q <= cdb_jump_flag_d;
      grant_cnt_q     <= grant_cnt_d;
    end
  end

  assign bus.cdb_valid     = cdb_valid_q;
  assign bus.cdb_rob_id    = cdb_rob_id_q;
  assign bus.cdb_result    = cdb_result_q;
  assign bus.cdb_target_pc = cdb_target_pc_q;
  assign bus.cdb_jump_flag = cdb_jump_flag_q;
  assign grant_cnt         = grant_cnt_q;

  a_ready_onehot : assert property (@(posedge clk) $onehot0(bus.req_ready));
  a_ready_needs_valid : assert property (@(posedge clk)
    (bus.req_ready & ~bus.req_valid) == '0);

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
//----------------------------------------------------------------------------
// tb_cdb_arbiter : directed vectors with hand-computed CDB expectations
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_cdb_arbiter;

  localparam int REQ_NUM  = 3;
  localparam int ROB_ID_W = 5;
  localparam int DATA_W   = 32;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        rollback_flag;
  logic [31:0] grant_cnt;

  cdb_arbiter_if #(.REQ_NUM(REQ_NUM), .ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)) bus ();

  cdb_arbiter #(.REQ_NUM(REQ_NUM), .ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .rollback_flag (rollback_flag),
    .bus           (bus),
    .grant_cnt     (grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rb;
    logic [2:0]  valid;
    logic [14:0] tags;
    logic [2:0]  exp_ready;
    logic        exp_cv;
    logic [4:0]  exp_id;
    logic        exp_zero;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[25];

  function automatic logic [14:0] t(input logic [4:0] a2, input logic [4:0] a1, input logic [4:0] a0);
    return {a2, a1, a0};
  endfunction

  function automatic vec_t mk(input logic r, input logic y, input logic b, input logic [2:0] v,
                              input logic [14:0] tg, input logic [2:0] er, input logic ecv,
                              input logic [4:0] eid, input logic ez, input logic [31:0] ec);
    vec_t x;
    x.rst = r; x.rdy = y; x.rb = b; x.valid = v; x.tags = tg;
    x.exp_ready = er; x.exp_cv = ecv; x.exp_id = eid; x.exp_zero = ez; x.exp_cnt = ec;
    return x;
  endfunction

  // Payload of each requester is derived from its tag so the bench can predict it.
  task automatic drive_tags(input logic [2:0] v, input logic [14:0] tg);
    bus.req_valid = v;
    for (int i = 0; i < REQ_NUM; i++) begin
      logic [4:0] tag;
      tag = tg[i*5 +: 5];
      bus.req_rob_id[i*5 +: 5]       = tag;
      bus.req_result[i*32 +: 32]     = 32'hC0DE_0000 | {27'd0, tag};
      bus.req_target_pc[i*32 +: 32]  = 32'h0000_1000 + {25'd0, tag, 2'b00};
      bus.req_jump_flag[i]           = tag[0];
    end
  endtask

  initial begin
    vecs[0]  = mk(0,1,0,3'b100,t(3,2,1),3'b100,1,5'd3,0,2);
    vecs[1]  = mk(0,1,0,3'b111,t(3,2,1),3'b001,1,5'd1,0,3);
    vecs[2]  = mk(0,1,0,3'b111,t(3,2,1),3'b010,1,5'd2,0,4);
    vecs[3]  = mk(0,1,0,3'b111,t(3,2,1),3'b100,1,5'd3,0,5);
    vecs[4]  = mk(0,1,0,3'b111,t(3,2,1),3'b001,1,5'd1,0,6);
    vecs[5]  = mk(0,1,0,3'b111,t(3,2,1),3'b010,1,5'd2,0,7);
    vecs[6]  = mk(0,1,0,3'b111,t(3,2,1),3'b100,1,5'd3,0,8);
    vecs[7]  = mk(0,1,0,3'b010,t(3,2,1),3'b010,1,5'd2,0,9);
    vecs[8]  = mk(0,1,0,3'b011,t(3,2,1),3'b001,1,5'd1,0,10);
    vecs[9]  = mk(0,1,0,3'b011,t(3,2,1),3'b010,1,5'd2,0,11);
    vecs[10] = mk(0,1,0,3'b001,t(3,2,0),3'b001,0,5'd0,0,11);
    vecs[11] = mk(0,1,0,3'b011,t(3,2,1),3'b010,1,5'd2,0,12);
    vecs[12] = mk(0,1,0,3'b100,t(5,2,1),3'b100,1,5'd5,0,13);
    vecs[13] = mk(0,1,1,3'b100,t(5,2,1),3'b000,0,5'd0,1,13);
    vecs[14] = mk(0,1,0,3'b110,t(5,2,1),3'b010,1,5'd2,0,14);
    vecs[15] = mk(0,0,1,3'b111,t(3,2,1),3'b000,0,5'd0,1,14);
    vecs[16] = mk(0,1,0,3'b111,t(3,2,1),3'b001,1,5'd1,0,15);
    vecs[17] = mk(0,1,0,3'b010,t(3,4,1),3'b010,1,5'd4,0,16);
    vecs[18] = mk(0,0,0,3'b111,t(3,4,1),3'b000,1,5'd4,0,16);
    vecs[19] = mk(0,0,0,3'b111,t(3,4,1),3'b000,1,5'd4,0,16);
    vecs[20] = mk(0,0,0,3'b111,t(3,4,1),3'b000,1,5'd4,0,16);
    vecs[21] = mk(0,1,0,3'b111,t(3,4,1),3'b100,1,5'd3,0,17);
    vecs[22] = mk(1,1,1,3'b111,t(3,2,1),3'b000,0,5'd0,1,0);
    vecs[23] = mk(0,1,0,3'b111,t(3,2,1),3'b001,1,5'd1,0,1);
    vecs[24] = mk(0,1,0,3'b000,t(3,2,1),3'b000,0,5'd1,0,1);

    // Reset with all requesters offering
    rst = 1'b1; rdy = 1'b1; rollback_flag = 1'b0;
    drive_tags(3'b111, t(3,2,1));
    #1;
    check("reset_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    check("reset_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    check("reset_rob_id", 64'(bus.cdb_rob_id), 64'd0);
    check("reset_result", 64'(bus.cdb_result), 64'd0);
    check("reset_target", 64'(bus.cdb_target_pc), 64'd0);
    check("reset_jump", 64'(bus.cdb_jump_flag), 64'd0);
    check("reset_cnt", 64'(grant_cnt), 64'd0);

    // Single request from requester 1
    rst = 1'b0;
    drive_tags(3'b010, t(0,7,0));
    bus.req_result[32 +: 32]    = 32'hDEAD_BEEF;
    bus.req_target_pc[32 +: 32] = 32'h0000_1000;
    bus.req_jump_flag[1]        = 1'b1;
    #1;
    check("single_ready", 64'(bus.req_ready), 64'b010);
    @(posedge clk); #1;
    check("single_cdb_valid", 64'(bus.cdb_valid), 64'd1);
    check("single_rob_id", 64'(bus.cdb_rob_id), 64'd7);
    check("single_result", 64'(bus.cdb_result), 64'hDEAD_BEEF);
    check("single_target", 64'(bus.cdb_target_pc), 64'h1000);
    check("single_jump", 64'(bus.cdb_jump_flag), 64'd1);
    check("single_cnt", 64'(grant_cnt), 64'd1);
    bus.req_valid = 3'b000;
    #1;
    check("idle_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    check("single_drop_valid", 64'(bus.cdb_valid), 64'd0);
    check("single_hold_id", 64'(bus.cdb_rob_id), 64'd7);
    check("single_hold_cnt", 64'(grant_cnt), 64'd1);

    for (int i = 0; i < 25; i++) begin
      logic [31:0] exp_res, exp_tgt;
      logic        exp_jmp;
      rst = vecs[i].rst; rdy = vecs[i].rdy; rollback_flag = vecs[i].rb;
      drive_tags(vecs[i].valid, vecs[i].tags);
      #1;
      check($sformatf("v%0d_ready", i), 64'(bus.req_ready), 64'(vecs[i].exp_ready));
      @(posedge clk); #1;
      if (vecs[i].exp_zero) begin
        exp_res = 32'd0; exp_tgt = 32'd0; exp_jmp = 1'b0;
      end else begin
        exp_res = 32'hC0DE_0000 | {27'd0, vecs[i].exp_id};
        exp_tgt = 32'h0000_1000 + {25'd0, vecs[i].exp_id, 2'b00};
        exp_jmp = vecs[i].exp_id[0];
      end
      check($sformatf("v%0d_cdb_valid", i), 64'(bus.cdb_valid), 64'(vecs[i].exp_cv));
      check($sformatf("v%0d_rob_id", i), 64'(bus.cdb_rob_id), 64'(vecs[i].exp_id));
      check($sformatf("v%0d_result", i), 64'(bus.cdb_result), 64'(exp_res));
      check($sformatf("v%0d_target", i), 64'(bus.cdb_target_pc), 64'(exp_tgt));
      check($sformatf("v%0d_jump", i), 64'(bus.cdb_jump_flag), 64'(exp_jmp));
      check($sformatf("v%0d_cnt", i), 64'(grant_cnt), 64'(vecs[i].exp_cnt));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
